// File: rtl/cga_init_sequencer.sv
// Population initialisation sequencer: loads the LFSR seed/tap, then requests gene
// initialisation for each individual in turn, with an optional per-request ack timeout.
module cga_init_sequencer #(
  parameter int                POPULATION   = 24,
  parameter int                IDX_W        = 8,
  parameter int                LFSR_W       = 256,
  parameter logic [2:0]        INIT_CODE    = 3'b000,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = LFSR_W'(64'hACE1_2468_1357_BDF9),
  parameter logic [LFSR_W-1:0] TAP_DEFAULT  = (LFSR_W'(1) << (LFSR_W-1)) | (LFSR_W'(1) << (LFSR_W-3))
                                            | (LFSR_W'(1) << (LFSR_W-6)) | (LFSR_W'(1) << (LFSR_W-11)),
  parameter int                ACK_TIMEOUT  = 16
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [2:0]        state_controller,
  input  logic              use_ext,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic [LFSR_W-1:0] tap_in,
  input  logic              gene_ack,
  output logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] tap,
  output logic              seed_ready,
  output logic              func_mem_ready,
  output logic              gene_req,
  output logic [IDX_W-1:0]  gene_index,
  output logic              init_done,
  output logic              init_err,
  output logic [2:0]        state_init
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_REQ   = 3'd2,
    S_WAIT  = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  localparam int                CNT_W    = $clog2(ACK_TIMEOUT + 2);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(POPULATION - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   tmo_cnt, cnt_nxt;
  logic [LFSR_W-1:0]  seed_nxt, tap_nxt, sel_seed;
  logic [IDX_W-1:0]   idx_nxt;
  logic               seed_ready_nxt, fmr_nxt, req_nxt, done_nxt, err_nxt;

  assign state_init = state;

  always_comb begin
    state_nxt      = state;
    seed_nxt       = seed;
    tap_nxt        = tap;
    seed_ready_nxt = seed_ready;
    fmr_nxt        = func_mem_ready;
    req_nxt        = gene_req;
    idx_nxt        = gene_index;
    done_nxt       = init_done;
    err_nxt        = init_err;
    cnt_nxt        = tmo_cnt;
    sel_seed       = use_ext ? seed_in : SEED_DEFAULT;

    if (state_controller != INIT_CODE) begin
      // Leaving init keeps the loaded seed/tap for the rest of the system.
      state_nxt = S_IDLE;
      req_nxt   = 1'b0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_LOAD;
        S_LOAD: begin
          // An all-zero seed would lock the LFSR up, so fall back to the built-in one.
          seed_nxt       = (sel_seed == '0) ? SEED_DEFAULT : sel_seed;
          tap_nxt        = use_ext ? tap_in : TAP_DEFAULT;
          seed_ready_nxt = 1'b1;
          idx_nxt        = '0;
          state_nxt      = S_REQ;
        end
        S_REQ: begin
          req_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (gene_ack) begin
            req_nxt = 1'b0;
            fmr_nxt = 1'b1;
            if (gene_index == LAST_IDX) begin
              done_nxt  = 1'b1;
              state_nxt = S_DONE;
            end else begin
              state_nxt = S_NEXT;
            end
          end else if (ACK_TIMEOUT > 0 && tmo_cnt == TMO_LAST) begin
            req_nxt   = 1'b0;
            err_nxt   = 1'b1;
            state_nxt = S_ERROR;
          end else if (ACK_TIMEOUT > 0) begin
            cnt_nxt = tmo_cnt + 1'b1;
          end
        end
        S_NEXT: begin
          if (gene_index != LAST_IDX) idx_nxt = gene_index + 1'b1;
          state_nxt = S_REQ;
        end
        S_DONE:  done_nxt = 1'b1;
        S_ERROR: err_nxt  = 1'b1;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state          <= S_IDLE;
      seed           <= '0;
      tap            <= '0;
      seed_ready     <= 1'b0;
      func_mem_ready <= 1'b0;
      gene_req       <= 1'b0;
      gene_index     <= '0;
      init_done      <= 1'b0;
      init_err       <= 1'b0;
      tmo_cnt        <= '0;
    end else begin
      state          <= state_nxt;
      seed           <= seed_nxt;
      tap            <= tap_nxt;
      seed_ready     <= seed_ready_nxt;
      func_mem_ready <= fmr_nxt;
      gene_req       <= req_nxt;
      gene_index     <= idx_nxt;
      init_done      <= done_nxt;
      init_err       <= err_nxt;
      tmo_cnt        <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_cga_init_sequencer.sv
// Directed bench for cga_init_sequencer: per-cycle comparison against a behavioural
// model, plus literal timing/value checks for each scenario.
module tb_cga_init_sequencer;

  localparam int         POP    = 24;
  localparam int         TMO    = 16;
  localparam logic [255:0] SEED_D = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
  localparam logic [255:0] TAP_D  = 256'hA420_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [255:0] S1     = 256'h1111_2222_3333_4444;
  localparam logic [255:0] T1     = 256'h0000_0000_8000_0001;
  localparam logic [255:0] S2     = 256'h5555_6666_7777_8888;

  localparam int ST_IDLE = 0, ST_LOAD = 1, ST_REQ = 2, ST_WAIT = 3, ST_NEXT = 4, ST_DONE = 5, ST_ERROR = 6;

  logic         CLOCK_50, reset, use_ext, gene_ack;
  logic [2:0]   state_controller;
  logic [255:0] seed_in, tap_in;

  logic [255:0] seed, tap, z_seed, z_tap;
  logic         seed_ready, func_mem_ready, gene_req, init_done, init_err;
  logic         z_seed_ready, z_func_mem_ready, z_gene_req, z_init_done, z_init_err;
  logic [7:0]   gene_index, z_gene_index;
  logic [2:0]   state_init, z_state_init;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;
  int ack_mode = 0;
  int held     = 0;
  int req_cnt[POP];
  int idx_bad;
  bit prev_req;
  bit found;

  cga_init_sequencer #(.POPULATION(POP), .IDX_W(8), .LFSR_W(256), .INIT_CODE(3'b000),
                       .SEED_DEFAULT(SEED_D), .TAP_DEFAULT(TAP_D), .ACK_TIMEOUT(TMO)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .state_controller(state_controller), .use_ext(use_ext),
    .seed_in(seed_in), .tap_in(tap_in), .gene_ack(gene_ack), .seed(seed), .tap(tap),
    .seed_ready(seed_ready), .func_mem_ready(func_mem_ready), .gene_req(gene_req),
    .gene_index(gene_index), .init_done(init_done), .init_err(init_err), .state_init(state_init));

  cga_init_sequencer #(.POPULATION(POP), .IDX_W(8), .LFSR_W(256), .INIT_CODE(3'b000),
                       .SEED_DEFAULT(SEED_D), .TAP_DEFAULT(TAP_D), .ACK_TIMEOUT(0)) dut0 (
    .CLOCK_50(CLOCK_50), .reset(reset), .state_controller(state_controller), .use_ext(use_ext),
    .seed_in(seed_in), .tap_in(tap_in), .gene_ack(gene_ack), .seed(z_seed), .tap(z_tap),
    .seed_ready(z_seed_ready), .func_mem_ready(z_func_mem_ready), .gene_req(z_gene_req),
    .gene_index(z_gene_index), .init_done(z_init_done), .init_err(z_init_err), .state_init(z_state_init));

  initial begin
    CLOCK_50 = 0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: what the outputs must be after each edge.
  int           m_st, m_idx, m_waited;
  logic [255:0] m_seed, m_tap;
  bit           m_sr, m_fmr, m_req, m_done, m_err;

  always @(posedge CLOCK_50) begin
    if (reset) begin
      m_st = ST_IDLE; m_seed = '0; m_tap = '0; m_sr = 0; m_fmr = 0;
      m_req = 0; m_done = 0; m_err = 0; m_idx = 0; m_waited = 0;
    end else if (state_controller != 3'b000) begin
      m_st = ST_IDLE; m_req = 0; m_done = 0; m_err = 0; m_idx = 0; m_waited = 0;
    end else if (m_st == ST_IDLE) begin
      m_st = ST_LOAD;
    end else if (m_st == ST_LOAD) begin
      m_seed = use_ext ? seed_in : SEED_D;
      if (m_seed == '0) m_seed = SEED_D;
      m_tap = use_ext ? tap_in : TAP_D;
      m_sr  = 1; m_idx = 0; m_st = ST_REQ;
    end else if (m_st == ST_REQ) begin
      m_req = 1; m_waited = 0; m_st = ST_WAIT;
    end else if (m_st == ST_WAIT) begin
      if (gene_ack) begin
        m_req = 0; m_fmr = 1;
        m_st  = (m_idx == POP - 1) ? ST_DONE : ST_NEXT;
        m_done = (m_idx == POP - 1);
      end else begin
        m_waited++;
        if (m_waited == TMO) begin
          m_req = 0; m_err = 1; m_st = ST_ERROR;
        end
      end
    end else if (m_st == ST_NEXT) begin
      m_idx = (m_idx < POP - 1) ? m_idx + 1 : m_idx;
      m_st  = ST_REQ;
    end
  end

  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      check("state_init",     state_init,     m_st);
      check("seed",           seed,           m_seed);
      check("tap",            tap,            m_tap);
      check("seed_ready",     seed_ready,     m_sr);
      check("func_mem_ready", func_mem_ready, m_fmr);
      check("gene_req",       gene_req,       m_req);
      check("gene_index",     gene_index,     m_idx);
      check("init_done",      init_done,      m_done);
      check("init_err",       init_err,       m_err);
    end
  end

  // Ack source: 0 tied high, 1 acked on the third WAIT cycle, 2 never.
  initial begin
    gene_ack = 1;
    forever begin
      @(negedge CLOCK_50);
      if (ack_mode == 0) begin
        gene_ack = 1;
      end else if (ack_mode == 1) begin
        held     = gene_req ? held + 1 : 0;
        gene_ack = (held == 3);
      end else begin
        gene_ack = 0;
      end
    end
  end

  task automatic leave_and_return();
    state_controller = 3'b001;
    repeat (2) @(negedge CLOCK_50);
    state_controller = 3'b000;
  endtask

  initial begin
    reset = 1; state_controller = 3'b111; use_ext = 0; seed_in = '0; tap_in = '0;
    @(negedge CLOCK_50);
    chk_en = 1;
    repeat (2) @(negedge CLOCK_50);
    check("rst_state", state_init, 0);
    check("rst_seed", seed, 0);
    check("rst_tap", tap, 0);
    check("rst_flags", {seed_ready, func_mem_ready, gene_req, init_done, init_err}, 0);
    check("rst_index", gene_index, 0);

    // Defaults, ack tied high.
    reset = 0; state_controller = 3'b000;
    for (int e = 1; e <= 80; e++) begin
      @(negedge CLOCK_50);
      if (e == 1)  check("s1_e1_load", state_init, ST_LOAD);
      if (e == 1)  check("s1_e1_sr", seed_ready, 0);
      if (e == 2)  check("s1_e2_sr", seed_ready, 1);
      if (e == 2)  check("s1_e2_seed", seed, SEED_D);
      if (e == 2)  check("s1_e2_tap", tap, TAP_D);
      if (e == 3)  check("s1_e3_req", gene_req, 1);
      if (e == 72) check("s1_e72_done", init_done, 0);
      if (e == 73) check("s1_e73_done", init_done, 1);
      if (e == 73) check("s1_e73_idx", gene_index, 23);
      if (e == 80) check("s1_e80_state", state_init, ST_DONE);
    end

    // External zero seed falls back to the default; tap is taken as given.
    use_ext = 1; seed_in = '0; tap_in = 256'd5;
    leave_and_return();
    for (int e = 1; e <= 80; e++) begin
      @(negedge CLOCK_50);
      if (e == 2) check("s2_seed", seed, SEED_D);
      if (e == 2) check("s2_tap", tap, 5);
      if (e == 80) check("s2_done", init_done, 1);
    end

    // Delayed ack: every index requested exactly once.
    use_ext = 0; ack_mode = 1;
    leave_and_return();
    for (int i = 0; i < POP; i++) req_cnt[i] = 0;
    idx_bad = 0; prev_req = 0;
    for (int c = 0; c < 400 && !init_done; c++) begin
      @(negedge CLOCK_50);
      if (gene_req && !prev_req) begin
        if (gene_index < POP) req_cnt[gene_index]++;
        else idx_bad++;
      end
      prev_req = gene_req;
    end
    check("s3_init_done", init_done, 1);
    check("s3_idx_range", idx_bad, 0);
    for (int i = 0; i < POP; i++) check($sformatf("s3_req_once_%0d", i), req_cnt[i], 1);

    // Controller leaves init mid-handshake at index 7.
    ack_mode = 0; use_ext = 1; seed_in = S1; tap_in = T1;
    leave_and_return();
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge CLOCK_50);
      found = (gene_index == 7 && gene_req);
    end
    check("s5_reach_idx7", found, 1);
    state_controller = 3'b001; seed_in = S2;
    @(negedge CLOCK_50);
    check("s5_idle", state_init, ST_IDLE);
    check("s5_req", gene_req, 0);
    check("s5_seed_held", seed, S1);
    check("s5_sr_held", seed_ready, 1);
    @(negedge CLOCK_50);
    state_controller = 3'b000;
    for (int e = 1; e <= 3; e++) begin
      @(negedge CLOCK_50);
      if (e == 2) check("s5_restart_idx", gene_index, 0);
      if (e == 2) check("s5_new_seed", seed, S2);
      if (e == 3) check("s5_restart_req", gene_req, 1);
    end

    // No ack: timeout on dut, indefinite WAIT on dut0.
    ack_mode = 2; use_ext = 0;
    leave_and_return();
    for (int e = 1; e <= 45; e++) begin
      @(negedge CLOCK_50);
      if (e == 18) check("s4_e18_wait", state_init, ST_WAIT);
      if (e == 18) check("s4_e18_req", gene_req, 1);
      if (e == 19) check("s4_e19_error", state_init, ST_ERROR);
      if (e == 19) check("s4_e19_err", init_err, 1);
      if (e == 19) check("s4_e19_req", gene_req, 0);
      if (e == 45) check("s4_e45_error", state_init, ST_ERROR);
      if (e == 45) check("s4_z_wait", z_state_init, ST_WAIT);
      if (e == 45) check("s4_z_req", z_gene_req, 1);
      if (e == 45) check("s4_z_err", z_init_err, 0);
    end

    // Reset while waiting for ack.
    leave_and_return();
    repeat (5) @(negedge CLOCK_50);
    check("s6_in_wait", state_init, ST_WAIT);
    check("s6_req_before", gene_req, 1);
    reset = 1;
    @(negedge CLOCK_50);
    check("s6_state", state_init, ST_IDLE);
    check("s6_seed_tap", {seed, tap} == '0, 1);
    check("s6_flags", {seed_ready, func_mem_ready, gene_req, init_done, init_err}, 0);
    check("s6_index", gene_index, 0);
    check("s6_z_req", z_gene_req, 0);
    reset = 0;
    repeat (3) @(negedge CLOCK_50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
